// File: rtl/riscv_fetch_pkg.sv
// rtl/riscv_fetch_pkg.sv - shared types and constants for the instruction fetch stage
package riscv_fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - in-order instruction buffer between fetch and decode
// Head is read from registered storage, so a push is visible one cycle later.
module fetch_fifo
  import riscv_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output fetch_entry_t head_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_pop, do_push;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '{instr: INSTR_NOP, pc: '0};
      end
    end else if (clear_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q <= rd_q + 1'b1;
      end
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC, credit-limited imem requests, redirect flush
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirects raise fetch_fault and halt fetch.
module instr_fetch_unit
  import riscv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            fetch_fault
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);
  localparam logic [0:0] S_RUN   = 1'(RUN);
  localparam logic [0:0] S_FLUSH = 1'(FLUSH);

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic            run_en_q;
  logic [XLEN-1:0] tag_q [FIFO_DEPTH];
  logic [AW-1:0]   tag_wr_q, tag_rd_q;

  logic [CW-1:0]   fifo_count;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic [CW:0]     credit_used;
  logic            req_hs, pop, push;
  logic [XLEN-1:0] redir_pc;
  logic            fault_q;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_d;
  assign redir_pc = redirect_pc;
  always_comb begin
    fault_d = fault_q;
    if (redirect_valid) fault_d = (redirect_pc[1:0] != 2'b00);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fault_q <= 1'b0;
    else        fault_q <= fault_d;
  end
`else
  logic unused_redirect_lsbs;
  assign redir_pc             = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign fault_q              = 1'b0;
`endif
  assign fetch_fault = fault_q;

  // A head leaving this cycle frees its slot, which keeps back-to-back fetch at depth 2.
  assign pop         = instr_valid & instr_ready;
  assign credit_used = {1'b0, out_q} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};
  assign imem_req_valid = run_en_q && (state_q == S_RUN) && !fault_q && (credit_used < DEPTH_C);
  assign imem_req_addr  = {pc_q[XLEN-1:2], 2'b00};
  assign req_hs         = imem_req_valid & imem_req_ready;
  assign push           = imem_rsp_valid && (state_q == S_RUN) && !redirect_valid;
  assign push_entry     = '{instr: imem_rsp_data, pc: tag_q[tag_rd_q]};

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    drop_d  = drop_q;
    out_d   = out_q + CW'(req_hs) - CW'(imem_rsp_valid);
    if (req_hs) pc_d = pc_plus4(pc_q);
    if (state_q == S_FLUSH && imem_rsp_valid) drop_d = drop_q - CW'(1);
    if (state_q == S_FLUSH && drop_d == '0) state_d = S_RUN;
    // Everything still in flight after this edge belongs to the wrong path.
    if (redirect_valid) begin
      pc_d    = redir_pc;
      drop_d  = out_d;
      state_d = (out_d != '0) ? S_FLUSH : S_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_RUN;
      pc_q     <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      run_en_q <= 1'b0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      run_en_q <= 1'b1;
      if (req_hs)         tag_wr_q <= tag_wr_q + 1'b1;
      if (imem_rsp_valid) tag_rd_q <= tag_rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (req_hs) tag_q[tag_wr_q] <= pc_q;
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (redirect_valid),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (fifo_count)
  );

  assign instr_valid = (fifo_count != '0);
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized scoreboard bench for instr_fetch_unit
module tb_instr_fetch_unit;
  import riscv_fetch_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid, instr_ready = 1'b0;
  logic [31:0] instr, instr_pc;
  logic        fetch_fault;

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .fetch_fault(fetch_fault)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0, n_deliv = 0;
  int p_rdy = 100, lat_min = 1, lat_max = 1, p_irdy = 100, p_redir = 0;
  logic        dir_redir = 1'b0;
  logic [31:0] dir_target = '0;

  typedef struct { int due; logic [31:0] addr; } mreq_t;
  typedef struct { int cyc; logic [31:0] pc; } redir_t;
  mreq_t  pend[$];
  redir_t rq[$];
  logic [31:0] exp_pc = RPC, req_exp = RPC;
  logic        fault_m = 1'b0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    case (a)
      32'h0: return 32'h0050_0093;
      32'h4: return 32'h0010_0113;
      32'h8: return 32'h0020_0193;
      default: return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_reset_values();
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_fetch_fault", 32'(fetch_fault), 32'd0);
  endtask

  // Instruction memory: in-order responses, latency >= 1, never back-pressured.
  initial begin : driver
    logic [31:0] t;
    forever begin
      @(negedge clk);
      if (rst_n && imem_req_valid && imem_req_ready) begin
        pend.push_back('{cyc + int'($urandom_range(lat_max, lat_min)), imem_req_addr});
        check("in_flight_le_depth", 32'(pend.size() <= DEPTH), 32'd1);
      end
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        pend.delete();
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b0;
      end else begin
        if (pend.size() > 0 && pend[0].due <= cyc) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = word_of(pend[0].addr);
          void'(pend.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
          imem_rsp_data  = $urandom;
        end
        imem_req_ready = ($urandom_range(99) < p_rdy);
        instr_ready    = ($urandom_range(99) < p_irdy);
        t = $urandom;
        if ($urandom_range(3) == 0) t = 32'hFFFF_FFE0 | (t & 32'h1F);
        if (dir_redir) begin
          redirect_valid = 1'b1;
          redirect_pc    = dir_target;
          dir_redir      = 1'b0;
        end else if ($urandom_range(999) < p_redir) begin
          redirect_valid = 1'b1;
          redirect_pc    = t;
        end else begin
          redirect_valid = 1'b0;
        end
        if (redirect_valid) rq.push_back('{cyc, redirect_pc});
      end
    end
  end

  // Reference: decode sees a gap-free PC stream restarting at each redirect target.
  initial begin : monitor
    logic        iv_stall, rq_stall;
    logic [31:0] p_instr, p_ipc, p_addr, t;
    int          last_redir;
    iv_stall = 1'b0; rq_stall = 1'b0; last_redir = -10;
    p_instr = '0; p_ipc = '0; p_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        iv_stall = 1'b0;
        rq_stall = 1'b0;
        continue;
      end
      while (rq.size() > 0 && rq[0].cyc < cyc) begin
        t = rq[0].pc;
`ifdef FETCH_MISALIGN_CHECK_EN
        fault_m = (t[1:0] != 2'b00);
`else
        t[1:0] = 2'b00;
`endif
        exp_pc     = t;
        req_exp    = t;
        last_redir = rq[0].cyc;
        void'(rq.pop_front());
      end
      check("fetch_fault", 32'(fetch_fault), 32'(fault_m));
      if (fault_m) check("no_req_while_fault", 32'(imem_req_valid), 32'd0);
      if (iv_stall && last_redir != cyc - 1) begin
        check("head_valid_held", 32'(instr_valid), 32'd1);
        check("head_instr_stable", instr, p_instr);
        check("head_pc_stable", instr_pc, p_ipc);
      end
      if (rq_stall && last_redir != cyc - 1) begin
        check("req_valid_held", 32'(imem_req_valid), 32'd1);
        check("req_addr_stable", imem_req_addr, p_addr);
      end
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, req_exp);
        req_exp = req_exp + 32'd4;
      end
      if (instr_valid && instr_ready) begin
        check("instr_pc", instr_pc, exp_pc);
        check("instr", instr, word_of(exp_pc));
        exp_pc = exp_pc + 32'd4;
        n_deliv++;
      end
      iv_stall = instr_valid && !instr_ready;
      rq_stall = imem_req_valid && !imem_req_ready;
      p_instr  = instr;
      p_ipc    = instr_pc;
      p_addr   = imem_req_addr;
    end
  end

  task automatic redirect_to(input logic [31:0] target);
    dir_target = target;
    dir_redir  = 1'b1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic release_reset();
    exp_pc  = RPC;
    req_exp = RPC;
    fault_m = 1'b0;
    rq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #2;
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_req_addr, RPC);
  endtask

  initial begin : main
    int d0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values();
    release_reset();

    cycles(4);
    d0 = n_deliv;
    cycles(20);
    check("throughput_1_per_cycle", 32'(n_deliv - d0), 32'd20);

    redirect_to(32'h100);          // lands on a cycle with both a request and a response
    cycles(12);

    p_irdy = 0;
    cycles(8);
    p_irdy = 100;
    cycles(10);

    lat_min = 3; lat_max = 3;
    cycles(10);
    redirect_to(32'h100);
    cycles(15);
    lat_min = 1; lat_max = 1;

    redirect_to(32'hFFFF_FFF4);
    cycles(12);

    redirect_to(32'h102);
    cycles(10);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("misalign_fault_set", 32'(fetch_fault), 32'd1);
    check("misalign_no_fetch", 32'(imem_req_valid), 32'd0);
`endif
    redirect_to(32'h200);
    d0 = n_deliv;
    cycles(10);
    check("fetch_resumes", 32'(n_deliv - d0 > 3), 32'd1);
    check("fault_clear", 32'(fetch_fault), 32'd0);

    p_rdy = 70; lat_min = 1; lat_max = 4; p_irdy = 70; p_redir = 30;
    d0 = n_deliv;
    cycles(3000);
    check("random_progress", 32'(n_deliv - d0 > 100), 32'd1);

    rst_n = 1'b0;
    #1;
    check_reset_values();
    p_rdy = 100; lat_min = 1; lat_max = 1; p_irdy = 100; p_redir = 0;
    cycles(2);
    release_reset();
    d0 = n_deliv;
    cycles(20);
    check("post_reset_stream", 32'(n_deliv - d0 > 15), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage feeding the `controller` decoder: owns the PC register, issues word requests to instruction memory over a valid/ready handshake, and buffers returned instructions in a small in-order FIFO. It presents `instr`/`instr_pc` to decode with valid/ready flow control. It accepts PC redirects from branch/jump resolution (`br_type` evaluation, JAL/JALR) and discards in-flight responses from the wrong path.

## Interface
- `RESET_PC`, 32'h0000_0000: PC fetched first after reset.
- `FIFO_DEPTH`, 2: instruction buffer entries. Power of two, ≥2. Also the maximum number of outstanding requests.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts the request.
- `imem_req_addr` out 32: word address; bits [1:0] are always 00.
- `imem_rsp_valid` in 1: response valid. Responses are in order, arrive ≥1 cycle after acceptance, and cannot be back-pressured.
- `imem_rsp_data` in 32: fetched instruction word.
- `redirect_valid` in 1: taken branch/jump this cycle.
- `redirect_pc` in 32: new fetch target.
- `instr_valid` out 1: FIFO head valid toward decode.
- `instr_ready` in 1: decode consumes the head.
- `instr` out 32: instruction to `controller`.
- `instr_pc` out 32: PC of `instr`.
- `fetch_fault` out 1: misaligned redirect flag. Present only when `FETCH_MISALIGN_CHECK_EN` is defined; tied 0 otherwise.

## Operation
- FSM states: `RUN` and `FLUSH`.
- `RUN` behaviour:
  - `imem_req_valid = (outstanding + fifo_count < FIFO_DEPTH)`.
  - On request handshake: `pc <= pc + 4` (32-bit wrap, 0xFFFF_FFFC → 0), `outstanding++`.
- Response in `RUN`: push `{imem_rsp_data, pc_of_request}` and decrement `outstanding`. PC tags travel in a parallel tag FIFO. Credit accounting guarantees there is always room, so no overflow is possible.
- Decode handshake (`instr_valid & instr_ready`) pops the FIFO head.
- Redirect (any state):
  - `pc <= redirect_pc`; FIFO cleared.
  - `drop_cnt <= outstanding`, plus 1 if a request handshake occurs in the same cycle; any response in the same cycle is excluded.
  - Next state is `FLUSH` if that count is >0, else `RUN`.
- `FLUSH`:
  - `imem_req_valid = 0`.
  - Each response decrements `drop_cnt` and is discarded.
  - At 0, go to `RUN`.
  - A further redirect in `FLUSH` updates `pc` and recomputes `drop_cnt` by the same rule.
- Simultaneous events in one cycle:
  - Redirect beats request handshake: the request is still counted in `drop_cnt`, its response is dropped, and PC takes `redirect_pc`.
  - Redirect beats response: the response is dropped.
  - Redirect with decode handshake: the old head is consumed normally, then the FIFO clears.
  - Push and pop together: count is unchanged; an empty FIFO receives the pushed entry.

## Timing
- Reset values (async on `rst_n` low):
  - `pc = RESET_PC`
  - `imem_req_valid = 0`
  - `instr_valid = 0`
  - `instr = 32'h0000_0013` (NOP)
  - `instr_pc = 0`
  - `fetch_fault = 0`
  - counters 0
  - state `RUN`
- First request: `imem_req_valid` rises in the first cycle after `rst_n` deasserts.
- Latency: a response in cycle N gives `instr_valid` in N+1 (registered FIFO, no combinational rsp→instr path).
- `imem_req_valid`/`imem_req_addr` stay stable until handshake unless a redirect occurs. Redirect cancels the pending request and changes the address next cycle.
- `instr`/`instr_pc` stay stable while `instr_valid & !instr_ready`.
- Throughput: one instruction per cycle sustained when `imem_req_ready=1`, response latency is 1, and `FIFO_DEPTH≥2`.
- Reset mid-operation: all state is cleared immediately. Responses arriving after reset, for requests issued before reset, are the system's responsibility. Instruction memory must also be reset.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - A redirect with `redirect_pc[1:0]≠0` clears the FIFO, drains as normal, and sets `fetch_fault=1`.
  - Fetching stops (`imem_req_valid=0`) until the next aligned redirect.
  - That aligned redirect clears `fetch_fault` in the same edge and resumes fetch.
- Not defined: `redirect_pc[1:0]` is forced to 00 and `fetch_fault` is tied 0.

## Structure
- Package `riscv_fetch_pkg`:
  - `fetch_state_e {RUN, FLUSH}`
  - `XLEN = 32`
  - `INSTR_NOP = 32'h0000_0013`
  - `fetch_entry_t {instr, pc}`
- One sub-module: `fetch_fifo`, a synchronous FIFO of `fetch_entry_t` with push/pop/clear and a count output. The top level holds the PC, credit counters, and FSM.

## Test plan
- Reset release, `imem_req_ready=1`, 1-cycle responses 0x00500093/0x00100113/… → requests to 0x0,0x4,0x8 on consecutive cycles; `instr` matches with `instr_pc` 0x0,0x4,0x8; one instruction per cycle.
- `instr_ready=0` for 5 cycles → at most `FIFO_DEPTH` requests outstanding+buffered; head is stable; no overflow; ordering preserved after release.
- Redirect to 0x100 with 2 responses in flight → state `FLUSH`, both responses dropped, next `instr_pc=0x100`, no stale instruction visible.
- Redirect in the same cycle as a request handshake and a response → request counted and dropped, response dropped, next address 0x100.
- PC at 0xFFFF_FFFC → next request address 0x0000_0000.
- With `FETCH_MISALIGN_CHECK_EN`: redirect to 0x102 → `fetch_fault=1`, no requests; redirect to 0x200 → fault clears, fetch resumes at 0x200.
